// File: rtl/vector_dot_product_flex.sv
// Serial fp32 dot product: one multiply-accumulate per clock over a latched vector pair of runtime length.
// The multiply/add cores round to nearest-even and treat subnormal operands and results as signed zero.
module vector_dot_product_flex #(
   parameter int LBUF = 128
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [32*LBUF-1:0]   A,
   input  logic [32*LBUF-1:0]   B,
   input  logic [31:0]          l,
   output logic [31:0]          result,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(LBUF + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   logic [32*LBUF-1:0]  a_st, b_st;
   logic [CW-1:0]       n, idx, n_req;
   logic [31:0]         acc, prod, sum;

   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s, g, st;
      logic [7:0]  ea, eb;
      logic [47:0] p;
      logic [22:0] m;
      logic [24:0] r;
      int          e;
      s  = a[31] ^ b[31];
      ea = a[30:23];
      eb = b[30:23];
      if ((ea == 8'hFF && a[22:0] != 23'h0) || (eb == 8'hFF && b[22:0] != 23'h0)) return 32'h7FC00000;
      if (ea == 8'hFF || eb == 8'hFF) return (ea == 8'h0 || eb == 8'h0) ? 32'h7FC00000 : {s, 8'hFF, 23'h0};
      if (ea == 8'h0 || eb == 8'h0) return {s, 31'h0};
      p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e = int'(ea) + int'(eb) - 127;
      if (p[47]) begin
         m  = p[46:24];
         g  = p[23];
         st = |p[22:0];
         e  = e + 1;
      end else begin
         m  = p[45:23];
         g  = p[22];
         st = |p[21:0];
      end
      r = {2'b01, m} + 25'(g & (st | m[0]));
      if (r[24]) begin
         e = e + 1;
         m = r[23:1];
      end else begin
         m = r[22:0];
      end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0) return {s, 31'h0};
      return {s, 8'(e), m};
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [26:0] mx, my;
      logic [27:0] s;
      logic [24:0] r;
      logic [22:0] m;
      logic        sticky;
      int          e, d, sh;
      sticky = 1'b0;
      if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) || (b[30:23] == 8'hFF && b[22:0] != 23'h0)) return 32'h7FC00000;
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) return (a[31] != b[31]) ? 32'h7FC00000 : a;
      if (a[30:23] == 8'hFF) return a;
      if (b[30:23] == 8'hFF) return b;
      if (a[30:23] == 8'h0 && b[30:23] == 8'h0) return {a[31] & b[31], 31'h0};
      if (a[30:23] == 8'h0) return b;
      if (b[30:23] == 8'h0) return a;
      if (a[30:0] >= b[30:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      // Three extra low bits (guard, round, sticky) keep round-to-nearest-even exact.
      mx = {1'b1, x[22:0], 3'b0};
      my = {1'b1, y[22:0], 3'b0};
      d  = int'(x[30:23]) - int'(y[30:23]);
      if (d >= 27) begin
         my = 27'd1;
      end else if (d > 0) begin
         sticky = |(my & ((27'd1 << d) - 27'd1));
         my     = (my >> d) | {26'd0, sticky};
      end
      e = int'(x[30:23]);
      if (x[31] == y[31]) begin
         s = {1'b0, mx} + {1'b0, my};
         if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 1;
         end
      end else begin
         s = {1'b0, mx} - {1'b0, my};
         if (s == 28'h0) return 32'h0;
         sh = 0;
         for (int i = 0; i <= 26; i++) if (s[i]) sh = 26 - i;
         s = s << sh;
         e = e - sh;
      end
      r = {1'b0, s[26:3]} + 25'(s[2] & (s[1] | s[0] | s[3]));
      if (r[24]) begin
         e = e + 1;
         m = r[23:1];
      end else begin
         m = r[22:0];
      end
      if (e >= 255) return {x[31], 8'hFF, 23'h0};
      if (e <= 0) return {x[31], 31'h0};
      return {x[31], 8'(e), m};
   endfunction

   assign prod  = fp_mul(a_st[32*idx +: 32], b_st[32*idx +: 32]);
   assign sum   = fp_add(acc, prod);
   assign n_req = (l > 32'(LBUF)) ? CW'(LBUF) : l[CW-1:0];

   // Vectors are captured on the accepting start so later input changes cannot disturb a run.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         result <= 32'h0;
         busy   <= 1'b0;
         done   <= 1'b0;
         acc    <= 32'h0;
         idx    <= '0;
         n      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_st <= A;
                  b_st <= B;
                  n    <= n_req;
                  acc  <= 32'h0;
                  idx  <= '0;
                  if (n_req == '0) begin
                     result <= 32'h0;
                     done   <= 1'b1;
                  end else begin
                     done  <= 1'b0;
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               acc <= sum;
               idx <= idx + 1'b1;
               if (idx == n - 1'b1) begin
                  result <= sum;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_dot_product_flex.sv
// Scoreboard bench for vector_dot_product_flex: elements are multiples of 0.25 so every partial sum is exact,
// letting an integer dot product serve as the bit-exact reference.
module tb_vector_dot_product_flex;

   localparam int LBUF = 128;

   logic                clk = 1'b0;
   logic                rst_n, start;
   logic [32*LBUF-1:0]  A, B;
   logic [31:0]         l, result;
   logic                busy, done;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          e0;
      string       name;
   } exp_t;

   exp_t  sb[$];
   int    errors = 0, checks = 0, completions = 0, issued = 0;
   int    cyc = 0, accCyc = -1, busyCnt = 0;
   logic  donePrev = 1'b0;
   int    qa[LBUF], qb[LBUF];

   vector_dot_product_flex #(.LBUF(LBUF)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .l(l),
      .result(result), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Encodes q / 2^fb as fp32; valid for |q| < 2^24.
   function automatic logic [31:0] toFp(int q, int fb);
      int          mag, p;
      logic [31:0] m;
      if (q == 0) return 32'h0;
      mag = (q < 0) ? -q : q;
      p = 0;
      for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
      m = 32'(mag) << (23 - p);
      return {q < 0, 8'(127 + p - fb), m[22:0]};
   endfunction

   function automatic logic [31:0] refDot(int len);
      int n;
      int s;
      n = (len > LBUF) ? LBUF : len;
      s = 0;
      for (int i = 0; i < n; i++) s += qa[i] * qb[i];
      return toFp(s, 4);
   endfunction

   task automatic packVecs();
      for (int i = 0; i < LBUF; i++) begin
         A[32*i +: 32] = toFp(qa[i], 2);
         B[32*i +: 32] = toFp(qb[i], 2);
      end
   endtask

   task automatic randomVecs();
      for (int i = 0; i < LBUF; i++) begin
         qa[i] = int'($urandom_range(80, 0)) - 40;
         qb[i] = int'($urandom_range(80, 0)) - 40;
      end
   endtask

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   task automatic applyStimulus(int len, logic [31:0] expRes, string name, bit track);
      @(negedge clk);
      packVecs();
      l     = 32'(len);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (track) begin
         sb.push_back('{res: expRes, lat: (len > LBUF) ? LBUF : len, e0: cyc, name: name});
         accCyc = cyc;
         issued++;
      end
   endtask

   task automatic waitDone();
      for (int k = 0; k < LBUF + 20; k++) begin
         if (completions >= issued) break;
         @(negedge clk);
         #1;
      end
      if (completions < issued) begin
         checks++;
         errors++;
         $display("[TB] FAIL completion timeout: got %0d completions expected %0d", completions, issued);
         sb.delete();
         completions = issued;
      end
   endtask

   // Monitor: a completion is done rising, or done held high across an accepting zero-length start.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (accCyc == cyc) busyCnt = 0;
      if (busy) busyCnt++;
      if (rst_n && done && (!donePrev || accCyc == cyc)) begin
         completions++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected done: got result %h with no pending run", result);
         end else begin
            e = sb.pop_front();
            checkOutput({e.name, " result"}, result, e.res);
            checkOutput({e.name, " latency"}, 32'(cyc - e.e0), 32'(e.lat));
            checkOutput({e.name, " busy cycles"}, 32'(busyCnt), 32'(e.lat));
         end
      end
      donePrev = done;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] want;
      int          len, r;
      rst_n = 1'b0;
      start = 1'b0;
      l     = 32'h0;
      A     = '0;
      B     = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset result", result, 32'h0);
      checkOutput("reset busy", 32'(busy), 32'h0);
      checkOutput("reset done", 32'(done), 32'h0);

      // 1.0,2.0,3.0 . 4.0,5.0,6.0 = 32.0
      randomVecs();
      qa[0] = 4;  qa[1] = 8;  qa[2] = 12;
      qb[0] = 16; qb[1] = 20; qb[2] = 24;
      applyStimulus(3, 32'h42000000, "s1 basic", 1);
      waitDone();

      applyStimulus(0, 32'h00000000, "s2 zero length", 1);
      waitDone();

      for (int i = 0; i < LBUF; i++) begin
         qa[i] = 4;
         qb[i] = 4;
      end
      applyStimulus(200, 32'h43000000, "s3 clamp", 1);
      waitDone();

      randomVecs();
      qa[0] = 6;
      qb[0] = -8;
      applyStimulus(1, 32'hC0400000, "s4 single", 1);
      waitDone();
      applyStimulus(1, 32'hC0400000, "s4 repeat", 1);
      waitDone();

      // Restart attempt and input churn while the run is in progress.
      randomVecs();
      qa[0] = 4;  qa[1] = 8;  qa[2] = 12;
      qb[0] = 16; qb[1] = 20; qb[2] = 24;
      applyStimulus(3, 32'h42000000, "s5 ignore restart", 1);
      @(posedge clk);
      #1 start = 1'b1;
      qa[0] = 40;
      qa[1] = -40;
      packVecs();
      l = 32'd100;
      @(posedge clk);
      #1 start = 1'b0;
      waitDone();

      for (int i = 0; i < LBUF; i++) begin
         qa[i] = 4;
         qb[i] = 4;
      end
      applyStimulus(200, 32'h0, "s6 aborted", 0);
      repeat (49) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("s6 reset result", result, 32'h0);
      checkOutput("s6 reset done", 32'(done), 32'h0);
      checkOutput("s6 reset busy", 32'(busy), 32'h0);
      applyStimulus(128, 32'h43000000, "s6 after reset", 1);
      waitDone();

      repeat (16) begin
         randomVecs();
         r = int'($urandom_range(9, 0));
         if (r == 0)      len = 0;
         else if (r == 1) len = 1;
         else if (r == 2) len = int'($urandom_range(300, 129));
         else             len = int'($urandom_range(128, 2));
         want = refDot(len);
         applyStimulus(len, want, "random", 1);
         randomVecs();
         packVecs();
         l = $urandom;
         waitDone();
      end

      checkOutput("scoreboard drained", 32'(sb.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
